// File: rtl/case_6_prod_accum.sv
// case_6_prod_accum
// Frame accumulator that sits downstream of the case_6 signed 8x4 multiplier.
// It collects LEN signed products over a valid/ready handshake and sums them
// at full precision. The sum is saturated to DOUT_WIDTH and presented on an
// output handshake. Frames are sequenced with ap_start/ap_done/ap_idle/ap_ready.
module case_6_prod_accum #(
   parameter int DIN_WIDTH  = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int DOUT_WIDTH = 8,
   parameter int LEN        = 4
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ap_start,
   output logic                  ap_done,
   output logic                  ap_idle,
   output logic                  ap_ready,
   input  logic [DIN_WIDTH-1:0]  in_data,
   input  logic                  in_vld,
   output logic                  in_rdy,
   output logic [DOUT_WIDTH-1:0] out_data,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic                  out_sat
);

   localparam int CNT_WIDTH = (LEN > 1) ? $clog2(LEN) : 1;
   localparam int SUM_WIDTH = (ACC_WIDTH > DOUT_WIDTH) ? ACC_WIDTH : DOUT_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LEN - 1);
   localparam logic signed [SUM_WIDTH-1:0] SAT_MAX =
      SUM_WIDTH'({1'b0, {(DOUT_WIDTH-1){1'b1}}});
   localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   // The accumulator must be wide enough that a full frame can never wrap.
   if (LEN < 1) begin : g_len_check
      $error("case_6_prod_accum: LEN must be at least 1");
   end
   if (ACC_WIDTH < DIN_WIDTH + $clog2(LEN)) begin : g_acc_width_check
      $error("case_6_prod_accum: ACC_WIDTH must be >= DIN_WIDTH + clog2(LEN)");
   end
   if (DOUT_WIDTH < 2) begin : g_dout_width_check
      $error("case_6_prod_accum: DOUT_WIDTH must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] din_ext;
   logic signed [ACC_WIDTH-1:0] acc_sum;
   logic signed [SUM_WIDTH-1:0] sum_wide;
   logic [DOUT_WIDTH-1:0]       sat_data;
   logic                        sat_flag;
   logic [CNT_WIDTH-1:0]        cnt;
   logic                        take;
   logic                        last;

   assign din_ext  = ACC_WIDTH'($signed(in_data));
   assign acc_sum  = acc + din_ext;
   assign sum_wide = SUM_WIDTH'(acc_sum);

   assign in_rdy   = (state == ACCUM);
   assign ap_idle  = (state == IDLE);
   assign take     = in_vld & in_rdy;
   assign last     = (cnt == CNT_LAST);
   assign ap_done  = out_vld & out_rdy;
   assign ap_ready = ap_done;

   // Clamp the running sum including the current product to the output range.
   always_comb begin
      sat_data = sum_wide[DOUT_WIDTH-1:0];
      sat_flag = 1'b0;
      if (sum_wide > SAT_MAX) begin
         sat_data = SAT_MAX[DOUT_WIDTH-1:0];
         sat_flag = 1'b1;
      end else if (sum_wide < SAT_MIN) begin
         sat_data = SAT_MIN[DOUT_WIDTH-1:0];
         sat_flag = 1'b1;
      end
   end

   // Frame sequencing state register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: start only from IDLE, finish on the last product, leave on output accept.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (ap_start) begin
               next_state = ACCUM;
            end
         end
         ACCUM: begin
            if (take && last) begin
               next_state = OUTPUT;
            end
         end
         OUTPUT: begin
            if (out_rdy) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Accumulator, product counter and the registered output holding stage.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc      <= '0;
         cnt      <= '0;
         out_data <= '0;
         out_vld  <= 1'b0;
         out_sat  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ap_start) begin
                  acc <= '0;
                  cnt <= '0;
               end
            end
            ACCUM: begin
               if (take) begin
                  acc <= acc_sum;
                  if (last) begin
                     cnt      <= '0;
                     out_data <= sat_data;
                     out_sat  <= sat_flag;
                     out_vld  <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_WIDTH'(1);
                  end
               end
            end
            OUTPUT: begin
               if (out_rdy) begin
                  out_vld <= 1'b0;
               end
            end
            default: begin
               out_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/case_6_prod_accum.md
Name: case_6_prod_accum

Overview:
- Downstream consumer of the case_6 signed 8x4 multiplier.
- Accepts a frame of LEN signed products over a valid/ready handshake and accumulates them at full precision.
- Saturates the sum to DOUT_WIDTH and presents it on an output handshake.
- Top-level sequencing uses ap_start/ap_done/ap_idle/ap_ready.

Parameters:
- DIN_WIDTH, 8: width of the signed product input; matches the multiplier dout.
- ACC_WIDTH, 16: internal accumulator width. Must be >= DIN_WIDTH + clog2(LEN); elaboration error otherwise.
- DOUT_WIDTH, 8: width of the saturated signed result.
- LEN, 4: products per frame, >= 1.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  frame start request, sampled only in IDLE.
- ap_done  out  1  one-cycle pulse when the result handshake completes.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- in_data  in  DIN_WIDTH  signed product.
- in_vld  in  1  in_data valid.
- in_rdy  out  1  block can accept in_data.
- out_data  out  DOUT_WIDTH  saturated signed frame sum.
- out_vld  out  1  out_data valid.
- out_rdy  in  1  consumer accepts out_data.
- out_sat  out  1  saturation occurred for this out_data; qualified by out_vld.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, acc=0, cnt=0.
  - out_data=0, out_vld=0, out_sat=0, in_rdy=0, ap_done=0, ap_ready=0, ap_idle=1.
  - Reset mid-frame discards partial sum and count; no output is produced.
- IDLE:
  - ap_idle=1, in_rdy=0.
  - ap_start=1 -> acc<=0, cnt<=0, next state ACCUM.
  - in_vld is ignored.
- ACCUM:
  - in_rdy=1 (registered or combinational; must equal (state==ACCUM)).
  - Transfer when in_vld & in_rdy: acc <= acc + sign_extend(in_data), cnt <= cnt+1.
  - No transfer -> acc and cnt hold; bubbles are allowed at any point.
  - Transfer with cnt==LEN-1:
    - out_data <= sat(acc + sext(in_data)).
    - out_sat set accordingly.
    - out_vld <= 1.
    - next state OUTPUT.
  - Latency: out_vld rises the cycle after the last accepted product.
  - LEN=1: the first transfer completes the frame.
- OUTPUT:
  - in_rdy=0, so products arriving now are back-pressured and not lost.
  - out_data, out_vld and out_sat are held stable until out_rdy=1.
  - Cycle with out_vld & out_rdy:
    - ap_done=1 and ap_ready=1 (combinational from the handshake or registered, but exactly one cycle each, in the same cycle).
    - out_vld<=0, next state IDLE.
  - ap_start during ACCUM/OUTPUT is ignored and is not queued.
- Restart: ap_start held high continuously means the next frame begins on the cycle after IDLE is entered, so there is at least one idle cycle between frames.
- Arithmetic:
  - Two's complement throughout; the accumulator cannot overflow given the ACC_WIDTH rule.
  - sat(x): x > 2^(DOUT_WIDTH-1)-1 -> max, out_sat=1; x < -2^(DOUT_WIDTH-1) -> min, out_sat=1; else x truncated exactly, out_sat=0.
  - Exact boundary values (127, -128 at defaults) give out_sat=0.
- cnt width: clog2(LEN), minimum 1; cnt never exceeds LEN-1.

Test Plan:
- Reset release, no start: ap_idle=1, in_rdy=0, out_vld=0 indefinitely; in_vld=1 with data 5 is not consumed.
- Start, products 10,-3,20,-7 back-to-back, out_rdy=1: out_vld the cycle after the 4th transfer, out_data=20, out_sat=0, ap_done/ap_ready pulse once in that cycle, then IDLE.
- Products 127,127,127,127 -> out_data=127, out_sat=1. Products -128 x4 -> out_data=-128, out_sat=1. Products 100,27,0,0 -> 127, out_sat=0.
- Bubbles and back-pressure:
  - in_vld toggled 1,0,0,1,... and out_rdy held low 5 cycles: sum is still correct (e.g. 1,2,3,4 -> 10).
  - out_data stays stable with out_vld=1 for all 5 stall cycles.
  - in_rdy=0 during OUTPUT; ap_done only on the accepting cycle.
- ap_start held high for 3 frames: no frame overlaps, one idle cycle between frames, ap_start pulses during ACCUM are ignored.
- ap_rst_n asserted after 2 of 4 products (mid-cycle, asynchronous): outputs immediately go to reset values; the next frame after restart sums only its own 4 products.
